reg_alu_pipe: RTL and testbench
===============================

Name: reg_alu_pipe

Overview:
Parametrised register-file plus ALU datapath with one registered execute stage and a write-back stage. Forwarding covers back-to-back dependencies. Adds immediate operand, carry flag, valid handshake and a debug read port. It is the next-generation datapath core that later CPU control logic drives, one operation per cycle.

Parameters:
DATA_W, 32, datapath and register width (>=4)
ADDR_W, 5, register address width
NUM_REGS, 32, implemented registers (2..2^ADDR_W); reg 0 hardwired zero
SHIFT_W, $clog2(DATA_W), shift-amount bits taken from operand B (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
in_valid  in  1  operation present this cycle
R_Addr_A  in  ADDR_W  operand A register
R_Addr_B  in  ADDR_W  operand B register
W_Addr  in  ADDR_W  destination register
Write_Reg  in  1  write result to W_Addr
B_Sel  in  1  0: B from register, 1: B = Imm
Imm  in  DATA_W  immediate operand
ALU_OP  in  3  operation code
Dbg_Addr  in  ADDR_W  debug read address
A  out  DATA_W  operand A as used (after forwarding), combinational
B  out  DATA_W  operand B as used (after forwarding/Imm), combinational
F  out  DATA_W  registered result
out_valid  out  1  F/flags updated for an op last cycle
OF  out  1  signed overflow, registered
ZF  out  1  zero, registered
CF  out  1  carry/borrow, registered
Dbg_Data  out  DATA_W  raw register-file contents at Dbg_Addr, combinational

Behaviour:
- Reset low (async): all registers, F, OF, ZF, CF, out_valid = 0; pending write-back discarded. Release synchronous to clk.
- ALU_OP: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB (A-B), 5 SLT signed (F=1/0), 6 SLL A<<B[SHIFT_W-1:0], 7 SRL logical.
- Cycle t, in_valid=1: A/B read, ALU evaluates; edge end of t: F, flags, out_valid=1 latched; WB register captures {Write_Reg && W_Addr!=0 && W_Addr<NUM_REGS, W_Addr, result}.
- Edge end of t+1: register file written from WB register. Latency result→F = 1 cycle; visible in file from cycle t+2.
- Forwarding: in cycle t+1, a read of WB address (valid WB) returns WB data, not file. WB register is the only forwarding source and always holds the newest write.
- Addr 0 or >=NUM_REGS: reads return 0; writes ignored (never forwarded).
- in_valid=0: F and flags hold, out_valid=0, WB valid cleared next edge.
- Write_Reg=0: F/flags update, no register change.
- ZF = (F==0) every op. OF: ADD/SUB signed overflow, else 0. CF: ADD carry-out, SUB borrow (A<B unsigned), else 0.
- Arithmetic modulo 2^DATA_W. Shift amount uses only the low SHIFT_W bits of B.
- Dbg_Data: no forwarding. A register written this edge shows its new value only after the edge.

Decomposition:
- Package reg_alu_pkg: ALU_OP localparams (OP_AND..OP_SRL), op width constant.
- Sub-module alu_core (combinational, DATA_W param): F, OF, CF outputs.
- Register file, forwarding mux and pipeline registers inline.

Test Plan:
1. Reset low mid-stream after r1=5 written → F=0, flags 0, out_valid=0, Dbg_Data(r1)=0; pending write not committed after release.
2. ADD r1=r0+Imm 5, next cycle ADD r1=r1+Imm 5, next ADD r2=r1+r1 (B_Sel=0) → F=5,10,20 on consecutive cycles (forwarding); Dbg r2=20 two cycles later.
3. r3=0x7FFFFFFF via Imm; ADD r3+Imm 1 → F=0x80000000, OF=1, CF=0, ZF=0. ADD 0xFFFFFFFF+1 → F=0, CF=1, ZF=1, OF=0.
4. SUB r1-r1 → F=0, ZF=1, CF=0. SUB r0-Imm 1 → F=0xFFFFFFFF, CF=1, OF=0. SLT(-1,1) → F=1. SLL(1, Imm 33) → F=2.
5. ADD W_Addr=0 Imm 7, then read r0 → A=0, Dbg 0. Write_Reg=0 with W_Addr=4 → r4 unchanged. in_valid=0 → F holds, out_valid=0.
6. DATA_W=8, NUM_REGS=8: 0x7F+1 → F=0x80, OF=1; write to addr 9 ignored; read addr 9 → 0.

Source files
------------

// File: rtl/reg_alu_pkg.sv
// Shared definitions for the register-file/ALU datapath.
// Holds the ALU operation encodings and the width of the operation field,
// so the interface, the ALU and the top agree on one set of codes.
package reg_alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND = 3'd0;
   localparam logic [OP_W-1:0] OP_OR  = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR = 3'd2;
   localparam logic [OP_W-1:0] OP_ADD = 3'd3;
   localparam logic [OP_W-1:0] OP_SUB = 3'd4;
   localparam logic [OP_W-1:0] OP_SLT = 3'd5;
   localparam logic [OP_W-1:0] OP_SLL = 3'd6;
   localparam logic [OP_W-1:0] OP_SRL = 3'd7;

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Operation/result bundle of the datapath.
// master: the control side (drives one operation per cycle, reads results).
// slave:  the datapath itself.
// Inputs : in_valid, R_Addr_A, R_Addr_B, W_Addr, Write_Reg, B_Sel, Imm,
//          ALU_OP, Dbg_Addr
// Outputs: A, B (operands as used), F, out_valid, OF, ZF, CF, Dbg_Data
interface reg_alu_pipe_if
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);

   logic              in_valid;
   logic [ADDR_W-1:0] R_Addr_A;
   logic [ADDR_W-1:0] R_Addr_B;
   logic [ADDR_W-1:0] W_Addr;
   logic              Write_Reg;
   logic              B_Sel;
   logic [DATA_W-1:0] Imm;
   logic [OP_W-1:0]   ALU_OP;
   logic [ADDR_W-1:0] Dbg_Addr;

   logic [DATA_W-1:0] A;
   logic [DATA_W-1:0] B;
   logic [DATA_W-1:0] F;
   logic              out_valid;
   logic              OF;
   logic              ZF;
   logic              CF;
   logic [DATA_W-1:0] Dbg_Data;

   modport master (
      output in_valid, R_Addr_A, R_Addr_B, W_Addr, Write_Reg, B_Sel, Imm,
             ALU_OP, Dbg_Addr,
      input  A, B, F, out_valid, OF, ZF, CF, Dbg_Data
   );

   modport slave (
      input  in_valid, R_Addr_A, R_Addr_B, W_Addr, Write_Reg, B_Sel, Imm,
             ALU_OP, Dbg_Addr,
      output A, B, F, out_valid, OF, ZF, CF, Dbg_Data
   );

endinterface

// File: rtl/reg_alu_pipe_alu_core.sv
// Combinational ALU of the datapath.
// a_i, b_i : operands
// op_i     : operation code (reg_alu_pkg OP_*)
// f_o      : result, modulo 2^DATA_W
// of_o     : signed overflow for ADD/SUB, else 0
// cf_o     : carry-out for ADD, borrow (a_i < b_i unsigned) for SUB, else 0
module alu_core
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   op_i,
   output logic [DATA_W-1:0] f_o,
   output logic              of_o,
   output logic              cf_o
);

   localparam int SHIFT_W = $clog2(DATA_W);
   localparam int MSB     = DATA_W - 1;

   logic [DATA_W:0]    sum;
   logic [DATA_W:0]    diff;
   logic [SHIFT_W-1:0] shamt;

   // One extra bit on each side of the add/subtract yields carry and borrow.
   assign sum   = {1'b0, a_i} + {1'b0, b_i};
   assign diff  = {1'b0, a_i} - {1'b0, b_i};
   assign shamt = b_i[SHIFT_W-1:0];

   // Result and flag selection; overflow is detected from operand and result
   // sign bits.
   always_comb begin
      f_o  = '0;
      of_o = 1'b0;
      cf_o = 1'b0;
      case (op_i)
         OP_AND: f_o = a_i & b_i;
         OP_OR:  f_o = a_i | b_i;
         OP_XOR: f_o = a_i ^ b_i;
         OP_ADD: begin
            f_o  = sum[MSB:0];
            cf_o = sum[DATA_W];
            of_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
         end
         OP_SUB: begin
            f_o  = diff[MSB:0];
            cf_o = diff[DATA_W];
            of_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
         end
         OP_SLT: f_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLL: f_o = a_i << shamt;
         OP_SRL: f_o = a_i >> shamt;
         default: f_o = '0;
      endcase
   end

endmodule

// File: rtl/reg_alu_pipe.sv
// Register file + ALU datapath with a registered execute stage and a
// write-back stage. Each valid operation produces F/flags one edge later and
// writes its destination one edge after that; a following operation reading
// that destination is served from the write-back register.
// clk   : rising-edge clock
// Reset : asynchronous, active-low reset
// bus   : operation inputs, operand/result outputs, debug read port
module reg_alu_pipe
   import reg_alu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic          clk,
   input  logic          Reset,
   reg_alu_pipe_if.slave bus
);

   logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

   logic [DATA_W-1:0] f_q, f_d;
   logic              of_q, of_d, zf_q, zf_d, cf_q, cf_d;
   logic              outValid_q, outValid_d;
   logic              wbValid_q, wbValid_d;
   logic [ADDR_W-1:0] wbAddr_q, wbAddr_d;
   logic [DATA_W-1:0] wbData_q, wbData_d;

   logic [DATA_W-1:0] opA, opB, aluF;
   logic              aluOF, aluCF;

   // An address names a real register only if it is non-zero and below
   // NUM_REGS; everything else reads as zero and is never written.
   function automatic logic isReg(input logic [ADDR_W-1:0] addr);
      isReg = 1'b0;
      for (int i = 1; i < NUM_REGS; i++)
         if (addr == ADDR_W'(i)) isReg = 1'b1;
   endfunction

   function automatic logic [DATA_W-1:0] readFile(input logic [ADDR_W-1:0] addr);
      readFile = '0;
      for (int i = 1; i < NUM_REGS; i++)
         if (addr == ADDR_W'(i)) readFile = regs_q[i];
   endfunction

   // The write-back register holds the only write not yet in the file, so it
   // is the single forwarding source. Its valid bit already excludes r0 and
   // out-of-range addresses.
   function automatic logic [DATA_W-1:0] readOperand(input logic [ADDR_W-1:0] addr);
      if (wbValid_q && (wbAddr_q == addr)) readOperand = wbData_q;
      else                                 readOperand = readFile(addr);
   endfunction

   always_comb begin
      opA = readOperand(bus.R_Addr_A);
      opB = bus.B_Sel ? bus.Imm : readOperand(bus.R_Addr_B);
   end

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a_i  (opA),
      .b_i  (opB),
      .op_i (bus.ALU_OP),
      .f_o  (aluF),
      .of_o (aluOF),
      .cf_o (aluCF)
   );

   // Next state of the execute and write-back stages: results and flags only
   // move on a valid operation; a bubble drops the pending write-back.
   always_comb begin
      f_d        = f_q;
      of_d       = of_q;
      zf_d       = zf_q;
      cf_d       = cf_q;
      outValid_d = bus.in_valid;
      wbValid_d  = 1'b0;
      wbAddr_d   = wbAddr_q;
      wbData_d   = wbData_q;
      if (bus.in_valid) begin
         f_d       = aluF;
         of_d      = aluOF;
         zf_d      = (aluF == '0);
         cf_d      = aluCF;
         wbValid_d = bus.Write_Reg && isReg(bus.W_Addr);
         wbAddr_d  = bus.W_Addr;
         wbData_d  = aluF;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         f_q        <= '0;
         of_q       <= 1'b0;
         zf_q       <= 1'b0;
         cf_q       <= 1'b0;
         outValid_q <= 1'b0;
         wbValid_q  <= 1'b0;
         wbAddr_q   <= '0;
         wbData_q   <= '0;
      end else begin
         f_q        <= f_d;
         of_q       <= of_d;
         zf_q       <= zf_d;
         cf_q       <= cf_d;
         outValid_q <= outValid_d;
         wbValid_q  <= wbValid_d;
         wbAddr_q   <= wbAddr_d;
         wbData_q   <= wbData_d;
      end
   end

   // Register file commit from the write-back register.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++)
            if (wbValid_q && (wbAddr_q == ADDR_W'(i))) regs_q[i] <= wbData_q;
      end
   end

   assign bus.A         = opA;
   assign bus.B         = opB;
   assign bus.F         = f_q;
   assign bus.out_valid = outValid_q;
   assign bus.OF        = of_q;
   assign bus.ZF        = zf_q;
   assign bus.CF        = cf_q;
   assign bus.Dbg_Data  = readFile(bus.Dbg_Addr);

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Self-checking bench for reg_alu_pipe: a 32-bit/32-register instance driven
// from a vector table with a result scoreboard, plus an 8-bit/8-register
// instance for narrow-width overflow and out-of-range addressing.
module tb_reg_alu_pipe;
   import reg_alu_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rA, rB, wAddr;
      logic        wr, bSel;
      logic [31:0] imm, expA, expB, expF;
      logic        expOF, expZF, expCF;
   } vec_t;

   typedef struct {
      logic [31:0] f;
      logic        ovf, zf, cf;
   } exp_t;

   logic clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   exp_t sbQ[$];

   always #5 clk = ~clk;

   reg_alu_pipe_if #(.DATA_W(32), .ADDR_W(5)) bus ();
   reg_alu_pipe_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();

   reg_alu_pipe #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
      .clk(clk), .Reset(Reset), .bus(bus.slave)
   );

   reg_alu_pipe #(.DATA_W(8), .ADDR_W(4), .NUM_REGS(8)) dut8 (
      .clk(clk), .Reset(Reset), .bus(bus8.slave)
   );

   // Single comparison point; every check in the bench goes through here.
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic [2:0] op, input logic [4:0] rA, input logic [4:0] rB,
                         input logic [4:0] wAddr, input logic wr, input logic bSel,
                         input logic [31:0] imm, input logic [31:0] expA, input logic [31:0] expB,
                         input logic [31:0] expF, input logic expOF, input logic expZF,
                         input logic expCF);
      vec_t v;
      v.op = op; v.rA = rA; v.rB = rB; v.wAddr = wAddr; v.wr = wr; v.bSel = bSel;
      v.imm = imm; v.expA = expA; v.expB = expB; v.expF = expF;
      v.expOF = expOF; v.expZF = expZF; v.expCF = expCF;
      vecs.push_back(v);
   endtask

   // Drive one operation at the falling edge, queue its expected result and
   // check the combinational operands before the rising edge.
   task automatic applyStimulus(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.ALU_OP    = v.op;
      bus.R_Addr_A  = v.rA;
      bus.R_Addr_B  = v.rB;
      bus.W_Addr    = v.wAddr;
      bus.Write_Reg = v.wr;
      bus.B_Sel     = v.bSel;
      bus.Imm       = v.imm;
      e.f = v.expF; e.ovf = v.expOF; e.zf = v.expZF; e.cf = v.expCF;
      sbQ.push_back(e);
      #1;
      check({tag, ".A"}, bus.A, v.expA);
      check({tag, ".B"}, bus.B, v.expB);
   endtask

   // After the rising edge, the result for the oldest queued operation must
   // be present with out_valid set.
   task automatic checkOutput(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      if (sbQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s.scoreboard: got empty queue expected entry", tag);
      end else begin
         e = sbQ.pop_front();
         check({tag, ".F"},  bus.F, e.f);
         check({tag, ".OF"}, 32'(bus.OF), 32'(e.ovf));
         check({tag, ".ZF"}, 32'(bus.ZF), 32'(e.zf));
         check({tag, ".CF"}, 32'(bus.CF), 32'(e.cf));
      end
   endtask

   task automatic idleCycle();
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus8.in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic runOp(input logic [2:0] op, input logic [4:0] rA, input logic [4:0] rB,
                        input logic [4:0] wAddr, input logic wr, input logic bSel,
                        input logic [31:0] imm, input logic [31:0] expA, input logic [31:0] expB,
                        input logic [31:0] expF, input logic expOF, input logic expZF,
                        input logic expCF, input string tag);
      vec_t v;
      v.op = op; v.rA = rA; v.rB = rB; v.wAddr = wAddr; v.wr = wr; v.bSel = bSel;
      v.imm = imm; v.expA = expA; v.expB = expB; v.expF = expF;
      v.expOF = expOF; v.expZF = expZF; v.expCF = expCF;
      applyStimulus(v, tag);
      checkOutput(tag);
   endtask

   // Narrow-instance operation: drive at the falling edge, sample after the
   // rising edge.
   task automatic op8(input logic [2:0] op, input logic [3:0] rA, input logic [3:0] wAddr,
                      input logic [7:0] imm);
      @(negedge clk);
      bus8.in_valid  = 1'b1;
      bus8.ALU_OP    = op;
      bus8.R_Addr_A  = rA;
      bus8.R_Addr_B  = 4'd0;
      bus8.W_Addr    = wAddr;
      bus8.Write_Reg = 1'b1;
      bus8.B_Sel     = 1'b1;
      bus8.Imm       = imm;
   endtask

   initial begin
      Reset = 1'b0;
      bus.in_valid = 1'b0; bus.ALU_OP = OP_AND; bus.R_Addr_A = '0; bus.R_Addr_B = '0;
      bus.W_Addr = '0; bus.Write_Reg = 1'b0; bus.B_Sel = 1'b0; bus.Imm = '0; bus.Dbg_Addr = '0;
      bus8.in_valid = 1'b0; bus8.ALU_OP = OP_AND; bus8.R_Addr_A = '0; bus8.R_Addr_B = '0;
      bus8.W_Addr = '0; bus8.Write_Reg = 1'b0; bus8.B_Sel = 1'b0; bus8.Imm = '0;
      bus8.Dbg_Addr = '0;

      //     op      rA rB  w   wr bS imm           expA          expB          expF          OF ZF CF
      addVec(OP_ADD, 0, 0,  1, 1, 1, 32'd5,        32'd0,        32'd5,        32'd5,        0, 0, 0);
      addVec(OP_ADD, 1, 0,  1, 1, 1, 32'd5,        32'd5,        32'd5,        32'd10,       0, 0, 0);
      addVec(OP_ADD, 1, 1,  2, 1, 0, 32'd0,        32'd10,       32'd10,       32'd20,       0, 0, 0);
      addVec(OP_ADD, 0, 0,  3, 1, 1, 32'h7FFFFFFF, 32'd0,        32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0);
      addVec(OP_ADD, 3, 0,  5, 1, 1, 32'd1,        32'h7FFFFFFF, 32'd1,        32'h80000000, 1, 0, 0);
      addVec(OP_ADD, 0, 0,  6, 1, 1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
      addVec(OP_ADD, 6, 0,  0, 0, 1, 32'd1,        32'hFFFFFFFF, 32'd1,        32'd0,        0, 1, 1);
      addVec(OP_SUB, 1, 1,  0, 0, 0, 32'd0,        32'd10,       32'd10,       32'd0,        0, 1, 0);
      addVec(OP_SUB, 0, 0,  7, 1, 1, 32'd1,        32'd0,        32'd1,        32'hFFFFFFFF, 0, 0, 1);
      addVec(OP_SLT, 7, 0,  0, 0, 1, 32'd1,        32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 0);
      addVec(OP_ADD, 0, 0,  8, 1, 1, 32'd1,        32'd0,        32'd1,        32'd1,        0, 0, 0);
      addVec(OP_SLL, 8, 0,  0, 0, 1, 32'd33,       32'd1,        32'd33,       32'd2,        0, 0, 0);
      addVec(OP_AND, 2, 0,  0, 0, 1, 32'h1C,       32'd20,       32'h1C,       32'h14,       0, 0, 0);
      addVec(OP_OR,  2, 0,  0, 0, 1, 32'h3,        32'd20,       32'h3,        32'h17,       0, 0, 0);
      addVec(OP_XOR, 2, 2,  0, 0, 0, 32'd0,        32'd20,       32'd20,       32'd0,        0, 1, 0);
      addVec(OP_SRL, 3, 0,  0, 0, 1, 32'd4,        32'h7FFFFFFF, 32'd4,        32'h07FFFFFF, 0, 0, 0);
      addVec(OP_SUB, 5, 0,  0, 0, 1, 32'd1,        32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 0, 0);
      addVec(OP_SLT, 1, 7,  0, 0, 0, 32'd0,        32'd10,       32'hFFFFFFFF, 32'd0,        0, 1, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      Reset = 1'b1;
      #1;
      check("reset.F", bus.F, 32'd0);
      check("reset.out_valid", 32'(bus.out_valid), 32'd0);

      // Back-to-back table: one operation per cycle, forwarding exercised.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], $sformatf("v%0d", i));
         checkOutput($sformatf("v%0d", i));
      end

      bus.Dbg_Addr = 5'd2;
      #1;
      check("dbg.r2", bus.Dbg_Data, 32'd20);

      // Write-back timing on the debug port: still in WB after the first
      // edge, in the file after the second; bubble holds F.
      runOp(OP_ADD, 0, 0, 10, 1, 1, 32'd20, 32'd0, 32'd20, 32'd20, 0, 0, 0, "wb10");
      bus.Dbg_Addr = 5'd10;
      #1;
      check("dbg.r10.pending", bus.Dbg_Data, 32'd0);
      idleCycle();
      check("bubble.out_valid", 32'(bus.out_valid), 32'd0);
      check("bubble.F", bus.F, 32'd20);
      check("dbg.r10.committed", bus.Dbg_Data, 32'd20);

      // r0 stays zero and is never forwarded.
      runOp(OP_ADD, 0, 0, 0, 1, 1, 32'd7, 32'd0, 32'd7, 32'd7, 0, 0, 0, "w0");
      runOp(OP_ADD, 0, 0, 0, 0, 1, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1, 0, "r0");
      bus.Dbg_Addr = 5'd0;
      #1;
      check("dbg.r0", bus.Dbg_Data, 32'd0);

      // Write_Reg low: F updates, r4 untouched.
      runOp(OP_ADD, 0, 0, 4, 0, 1, 32'd99, 32'd0, 32'd99, 32'd99, 0, 0, 0, "nowr");
      idleCycle();
      idleCycle();
      check("hold.F", bus.F, 32'd99);
      bus.Dbg_Addr = 5'd4;
      #1;
      check("dbg.r4", bus.Dbg_Data, 32'd0);

      // Narrow instance: 0x7F+1 overflow, out-of-range address 9.
      op8(OP_ADD, 4'd0, 4'd1, 8'h7F);
      op8(OP_ADD, 4'd1, 4'd2, 8'h01);
      #1;
      check("n8.A.fwd", 32'(bus8.A), 32'h7F);
      @(posedge clk);
      #1;
      check("n8.F", 32'(bus8.F), 32'h80);
      check("n8.OF", 32'(bus8.OF), 32'd1);
      check("n8.CF", 32'(bus8.CF), 32'd0);
      op8(OP_ADD, 4'd0, 4'd9, 8'h55);
      op8(OP_ADD, 4'd9, 4'd0, 8'h00);
      #1;
      check("n8.A.r9", 32'(bus8.A), 32'd0);
      @(posedge clk);
      #1;
      check("n8.F.r9", 32'(bus8.F), 32'd0);
      check("n8.ZF.r9", 32'(bus8.ZF), 32'd1);
      idleCycle();
      bus8.Dbg_Addr = 4'd9;
      #1;
      check("n8.dbg.r9", 32'(bus8.Dbg_Data), 32'd0);
      bus8.Dbg_Addr = 4'd1;
      #1;
      check("n8.dbg.r1", 32'(bus8.Dbg_Data), 32'h7F);

      // Reset mid-stream with a write to r11 still pending in write-back.
      runOp(OP_ADD, 0, 0, 11, 1, 1, 32'd5, 32'd0, 32'd5, 32'd5, 0, 0, 0, "prerst");
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      check("rst.F", bus.F, 32'd0);
      check("rst.OF", 32'(bus.OF), 32'd0);
      check("rst.ZF", 32'(bus.ZF), 32'd0);
      check("rst.CF", 32'(bus.CF), 32'd0);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      bus.Dbg_Addr = 5'd1;
      #1;
      check("rst.dbg.r1", bus.Dbg_Data, 32'd0);
      @(negedge clk);
      Reset = 1'b1;
      idleCycle();
      idleCycle();
      bus.Dbg_Addr = 5'd11;
      #1;
      check("rst.dbg.r11", bus.Dbg_Data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
